// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the single external memory bus between the CPU core
// and the PRC display master. Owns the address/data mux, the CPU stall, the
// PRC grant handshake and the local service of interrupt-vector reads.
module bus_arbiter #(
  parameter int MAX_PRC_BURST = 16,  // PRC transfers per grant before forced return (1..255)
  parameter int CPU_MIN_SLOTS = 2    // CPU-owned cycles between PRC grants (1..15)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] cpu_address,
  input  logic [1:0]  cpu_bus_status,
  input  logic [7:0]  cpu_write_data,
  output logic [7:0]  cpu_read_data,
  output logic        cpu_wait,
  input  logic [7:0]  irq_vector,
  output logic        irq_ack,
  input  logic        prc_req,
  output logic        prc_gnt,
  input  logic [23:0] prc_address,
  input  logic        prc_write,
  input  logic [7:0]  prc_write_data,
  output logic [7:0]  prc_read_data,
  output logic        prc_ack,
  output logic [23:0] mem_address,
  output logic [7:0]  mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [7:0]  mem_read_data
);

  localparam logic [1:0] STATUS_IRQ   = 2'd1;
  localparam logic [1:0] STATUS_WRITE = 2'd2;
  localparam logic [1:0] STATUS_READ  = 2'd3;

  // Transfer index that closes a grant, and the slot count that lets the
  // PRC back in. The current CPU cycle counts toward the minimum, so the CPU
  // owns exactly CPU_MIN_SLOTS cycles between two back-to-back grants.
  localparam logic [7:0] BURST_LAST = 8'(MAX_PRC_BURST - 1);
  localparam logic [3:0] SLOT_SAT   = 4'(CPU_MIN_SLOTS);
  localparam logic [3:0] SLOT_LAST  = 4'(CPU_MIN_SLOTS - 1);

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    TO_PRC  = 2'd1,
    PRC_OWN = 2'd2,
    TO_CPU  = 2'd3
  } state_t;

  state_t     state_reg;
  logic       cpu_wait_reg;
  logic       prc_gnt_reg;
  logic       irq_ack_reg;
  logic       prc_ack_reg;
  logic       cpu_rd_tag_reg;   // previous cycle's mem_read came from the CPU
  logic       prc_rd_tag_reg;   // previous cycle's mem_read came from the PRC
  logic [7:0] burst_reg;
  logic [3:0] slot_reg;

  logic cpu_active;
  logic cpu_mem_rd;
  logic cpu_mem_wr;
  logic cpu_irq;
  logic prc_issue;
  logic slot_ok;

  // Bus mux, strobes and read-data routing for the current cycle.
  always_comb begin
    cpu_active     = (state_reg == CPU_OWN) & ~cpu_wait_reg;
    cpu_mem_rd     = cpu_active & (cpu_bus_status == STATUS_READ);
    cpu_mem_wr     = cpu_active & (cpu_bus_status == STATUS_WRITE);
    cpu_irq        = cpu_active & (cpu_bus_status == STATUS_IRQ);
    prc_issue      = (state_reg == PRC_OWN) & prc_req;
    slot_ok        = (slot_reg >= SLOT_LAST);
    mem_read       = cpu_mem_rd | (prc_issue & ~prc_write);
    mem_write      = cpu_mem_wr | (prc_issue & prc_write);
    mem_address    = cpu_address;
    mem_write_data = cpu_write_data;
    if (state_reg == PRC_OWN) begin
      mem_address    = prc_address;
      mem_write_data = prc_write_data;
    end
    // The irq vector is returned in the same cycle as the irq read, unless a
    // CPU memory read from the previous cycle is returning right now.
    cpu_read_data = (cpu_irq & ~cpu_rd_tag_reg) ? irq_vector : mem_read_data;
    prc_read_data = prc_rd_tag_reg ? mem_read_data : 8'h00;
  end

  assign cpu_wait = cpu_wait_reg;
  assign prc_gnt  = prc_gnt_reg;
  assign irq_ack  = irq_ack_reg;
  assign prc_ack  = prc_ack_reg;

  // Ownership FSM with registered handshake outputs, counters and read tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= CPU_OWN;
      cpu_wait_reg   <= 1'b0;
      prc_gnt_reg    <= 1'b0;
      irq_ack_reg    <= 1'b0;
      prc_ack_reg    <= 1'b0;
      cpu_rd_tag_reg <= 1'b0;
      prc_rd_tag_reg <= 1'b0;
      burst_reg      <= 8'd0;
      slot_reg       <= 4'd0;
    end else begin
      irq_ack_reg    <= cpu_irq;
      prc_ack_reg    <= prc_issue;
      cpu_rd_tag_reg <= cpu_mem_rd;
      prc_rd_tag_reg <= prc_issue & ~prc_write;
      case (state_reg)
        CPU_OWN: begin
          if (slot_reg < SLOT_SAT) begin
            slot_reg <= slot_reg + 4'd1;
          end
          // The CPU access on the bus this cycle completes; the stall starts next cycle.
          if (prc_req && slot_ok) begin
            state_reg    <= TO_PRC;
            cpu_wait_reg <= 1'b1;
          end
        end
        TO_PRC: begin
          state_reg   <= PRC_OWN;
          prc_gnt_reg <= 1'b1;
          burst_reg   <= 8'd0;
        end
        PRC_OWN: begin
          if (!prc_req) begin
            state_reg   <= TO_CPU;
            prc_gnt_reg <= 1'b0;
          end else begin
            burst_reg <= burst_reg + 8'd1;
            if (burst_reg == BURST_LAST) begin
              state_reg   <= TO_CPU;
              prc_gnt_reg <= 1'b0;
            end
          end
        end
        TO_CPU: begin
          state_reg    <= CPU_OWN;
          cpu_wait_reg <= 1'b0;
          slot_reg     <= 4'd0;
        end
        default: begin
          state_reg    <= CPU_OWN;
          cpu_wait_reg <= 1'b0;
          prc_gnt_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized and directed stimulus for bus_arbiter. Drivers
// push expected bus transactions into queues; a negedge monitor pops them
// whenever the DUT strobes memory or returns data, and tracks grant shapes.
module tb_bus_arbiter;

  localparam int MAX_B = 16;
  localparam int MIN_S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] cpu_address;
  logic [1:0]  cpu_bus_status;
  logic [7:0]  cpu_write_data;
  logic [7:0]  cpu_read_data;
  logic        cpu_wait;
  logic [7:0]  irq_vector;
  logic        irq_ack;
  logic        prc_req;
  logic        prc_gnt;
  logic [23:0] prc_address;
  logic        prc_write;
  logic [7:0]  prc_write_data;
  logic [7:0]  prc_read_data;
  logic        prc_ack;
  logic [23:0] mem_address;
  logic [7:0]  mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_read_data;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_PRC_BURST(MAX_B), .CPU_MIN_SLOTS(MIN_S)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_bus_status(cpu_bus_status),
    .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
    .cpu_wait(cpu_wait), .irq_vector(irq_vector), .irq_ack(irq_ack),
    .prc_req(prc_req), .prc_gnt(prc_gnt), .prc_address(prc_address),
    .prc_write(prc_write), .prc_write_data(prc_write_data),
    .prc_read_data(prc_read_data), .prc_ack(prc_ack),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  typedef struct { bit prc; bit wr; logic [23:0] addr; logic [7:0] data; } bus_t;
  typedef struct { logic [1:0] st; logic [23:0] addr; logic [7:0] data; } cpu_op_t;
  typedef struct { bit wr; logic [23:0] addr; logic [7:0] data; } prc_op_t;

  int total = 0;
  int bad   = 0;

  bus_t       bus_q[$];
  logic [7:0] irq_q[$];
  cpu_op_t    cpu_dir_q[$];
  prc_op_t    prc_work[$];
  int         lens_q[$];
  int         free_q[$];
  int         low_q[$];

  bit cpu_hold = 0, prc_hold = 0, last_cpu_read = 0, cpu_rand_en = 0;
  int prc_gap_pct = 0;
  int prc_issued = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents as a fixed function of address; single-cycle read latency.
  function automatic logic [7:0] rdf(input logic [23:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h3C;
  endfunction

  always @(posedge clk) mem_read_data <= mem_read ? rdf(mem_address) : 8'($urandom);

  // One bus cycle: drive both masters just after the edge and record what the
  // arbiter accepts this cycle (the CPU when not stalled, the PRC when granted).
  task automatic tick();
    cpu_op_t op;
    bus_t    e;
    @(posedge clk);
    #1;
    if (!cpu_hold) begin
      op.st = 2'd0; op.addr = 24'd0; op.data = 8'd0;
      if (cpu_dir_q.size() != 0) op = cpu_dir_q.pop_front();
      else if (cpu_rand_en) begin
        op.st = 2'($urandom_range(3)); op.addr = 24'($urandom); op.data = 8'($urandom);
      end
      if (last_cpu_read && op.st == 2'd1) op.st = 2'd0;
      cpu_bus_status = op.st; cpu_address = op.addr; cpu_write_data = op.data;
      irq_vector = (op.st == 2'd1) ? op.data : 8'($urandom);
    end
    last_cpu_read = 1'b0;
    if (cpu_bus_status != 2'd0 && !cpu_wait) begin
      if (cpu_bus_status == 2'd1) irq_q.push_back(irq_vector);
      else begin
        e.prc = 1'b0; e.wr = (cpu_bus_status == 2'd2);
        e.addr = cpu_address; e.data = cpu_write_data;
        bus_q.push_back(e);
      end
      last_cpu_read = (cpu_bus_status == 2'd3);
      cpu_hold = 1'b0;
    end else begin
      cpu_hold = (cpu_bus_status != 2'd0);
    end
    if (!prc_hold) prc_req = (prc_work.size() != 0) && (int'($urandom_range(99)) >= prc_gap_pct);
    if (prc_req) begin
      prc_address = prc_work[0].addr; prc_write = prc_work[0].wr; prc_write_data = prc_work[0].data;
      if (prc_gnt) begin
        e.prc = 1'b1; e.wr = prc_work[0].wr; e.addr = prc_work[0].addr; e.data = prc_work[0].data;
        bus_q.push_back(e);
        void'(prc_work.pop_front());
        prc_issued++;
        prc_hold = 1'b0;
      end else begin
        prc_hold = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && prc_work.size() != 0; i++) tick();
    check("prc_drain", prc_work.size(), 0);
  endtask

  task automatic push_prc(input bit wr, input logic [23:0] a, input logic [7:0] d);
    prc_op_t p;
    p.wr = wr; p.addr = a; p.data = d;
    prc_work.push_back(p);
  endtask

  task automatic push_cpu(input logic [1:0] st, input logic [23:0] a, input logic [7:0] d);
    cpu_op_t c;
    c.st = st; c.addr = a; c.data = d;
    cpu_dir_q.push_back(c);
  endtask

  // Monitor state
  bit         exp_irq_ack = 0, exp_prc_ack = 0, exp_cpu_rd = 0, exp_prc_rd = 0;
  logic [7:0] exp_cpu_data = 0, exp_prc_data = 0;
  bit         n_irq_ack, n_prc_ack, n_cpu_rd, n_prc_rd;
  logic [7:0] n_cpu_data, n_prc_data, mon_vec;
  bus_t       mon_e;
  bit         prev_gnt = 0;
  int         gnt_xfers = 0, cpu_free = 0, gnt_low = 0;

  // Scoreboard monitor: compares strobes and returned data against the queues.
  always @(negedge clk) begin
    n_irq_ack = 0; n_prc_ack = 0; n_cpu_rd = 0; n_prc_rd = 0;
    n_cpu_data = 8'h00; n_prc_data = 8'h00;
    check("irq_ack", irq_ack, exp_irq_ack);
    check("prc_ack", prc_ack, exp_prc_ack);
    if (exp_cpu_rd) check("cpu_read_data", cpu_read_data, exp_cpu_data);
    if (exp_prc_rd) check("prc_read_data", prc_read_data, exp_prc_data);
    check("gnt_implies_wait", prc_gnt & ~cpu_wait, 1'b0);
    if (irq_q.size() != 0) begin
      mon_vec = irq_q.pop_front();
      check("irq_vector", cpu_read_data, mon_vec);
      n_irq_ack = 1'b1;
    end
    if (mem_read || mem_write) begin
      check("strobe_expected", bus_q.size() != 0, 1'b1);
      if (bus_q.size() != 0) begin
        mon_e = bus_q.pop_front();
        check("strobe_kind", {mem_write, mem_read}, mon_e.wr ? 2'b10 : 2'b01);
        check("mem_address", mem_address, mon_e.addr);
        if (mon_e.wr) check("mem_write_data", mem_write_data, mon_e.data);
        check("bus_owner", prc_gnt, mon_e.prc);
        if (mon_e.prc) begin
          n_prc_ack = 1'b1;
          if (!mon_e.wr) begin n_prc_rd = 1'b1; n_prc_data = rdf(mon_e.addr); end
        end else if (!mon_e.wr) begin
          n_cpu_rd = 1'b1; n_cpu_data = rdf(mon_e.addr);
        end
      end
    end
    if (bus_q.size() != 0) begin
      check("missing_strobe", bus_q.size(), 0);
      bus_q.delete();
    end
    // Grant shape: transfers per grant, CPU cycles and gnt-low cycles between grants.
    if (prc_gnt && !prev_gnt) begin
      check("cpu_slots_before_grant", cpu_free >= MIN_S, 1'b1);
      free_q.push_back(cpu_free);
      low_q.push_back(gnt_low);
      gnt_xfers = 0;
    end
    if (!prc_gnt && prev_gnt) begin
      check("grant_len_limit", gnt_xfers <= MAX_B, 1'b1);
      lens_q.push_back(gnt_xfers);
      cpu_free = 0;
      gnt_low = 0;
    end
    if (prc_gnt && (mem_read || mem_write)) gnt_xfers++;
    if (!prc_gnt) gnt_low++;
    if (!cpu_wait) cpu_free++;
    prev_gnt = prc_gnt;
    if (reset) begin
      n_irq_ack = 0; n_prc_ack = 0; n_cpu_rd = 0; n_prc_rd = 0;
      cpu_free = 0; gnt_low = 0;
    end
    exp_irq_ack = n_irq_ack; exp_prc_ack = n_prc_ack;
    exp_cpu_rd = n_cpu_rd; exp_prc_rd = n_prc_rd;
    exp_cpu_data = n_cpu_data; exp_prc_data = n_prc_data;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_lens[$];
    int rem;
    reset = 1'b1;
    cpu_address = 24'd0; cpu_bus_status = 2'd0; cpu_write_data = 8'd0; irq_vector = 8'd0;
    prc_req = 1'b0; prc_address = 24'd0; prc_write = 1'b0; prc_write_data = 8'd0;
    idle(3);
    @(negedge clk);
    check("rst_cpu_wait", cpu_wait, 1'b0);
    check("rst_prc_gnt", prc_gnt, 1'b0);
    check("rst_strobes", {mem_read, mem_write}, 2'b00);
    reset = 1'b0;
    idle(4);

    // CPU read with the PRC idle
    push_cpu(2'd3, 24'h001234, 8'h00);
    tick();
    @(negedge clk);
    check("t1_cpu_wait", cpu_wait, 1'b0);
    check("t1_mem_read", mem_read, 1'b1);
    idle(4);

    // Three PRC reads from idle: stall next cycle, dead cycle, grant, release
    push_prc(0, 24'h001000, 8'h00); push_prc(0, 24'h001001, 8'h00); push_prc(0, 24'h001002, 8'h00);
    tick(); @(negedge clk); check("t2_wait_req_cycle", cpu_wait, 1'b0);
    tick(); @(negedge clk); check("t2_wait_dead", cpu_wait, 1'b1);
    check("t2_gnt_dead", prc_gnt, 1'b0);
    check("t2_strobes_dead", {mem_read, mem_write}, 2'b00);
    tick(); @(negedge clk); check("t2_gnt", prc_gnt, 1'b1);
    tick(); tick(); tick();
    @(negedge clk); check("t2_gnt_after_drop", prc_gnt, 1'b1);
    tick(); @(negedge clk); check("t2_gnt_release", prc_gnt, 1'b0);
    check("t2_wait_release", cpu_wait, 1'b1);
    tick(); @(negedge clk); check("t2_wait_back", cpu_wait, 1'b0);
    idle(4);

    // 40 back-to-back PRC transfers: forced exits and CPU slots between grants
    lens_q.delete(); free_q.delete(); low_q.delete();
    for (int i = 0; i < 40; i++) push_prc(0, 24'h003000 + 24'(i), 8'h00);
    drain(300);
    idle(5);
    rem = 40;
    while (rem > 0) begin
      exp_lens.push_back(rem > MAX_B ? MAX_B : rem);
      rem -= MAX_B;
    end
    check("t3_grant_count", lens_q.size(), exp_lens.size());
    check("t3_rise_count", free_q.size(), exp_lens.size());
    foreach (exp_lens[i]) if (i < lens_q.size()) check("t3_grant_len", lens_q[i], exp_lens[i]);
    for (int i = 1; i < free_q.size(); i++) begin
      check("t3_cpu_slots", free_q[i], MIN_S);
      check("t3_gnt_low_cycles", low_q[i], MIN_S + 2);
    end

    // irq read and PRC request in the same cycle
    push_cpu(2'd1, 24'h000000, 8'h0C);
    push_prc(0, 24'h004000, 8'h00); push_prc(0, 24'h004001, 8'h00);
    tick(); @(negedge clk);
    check("t4_vector", cpu_read_data, 8'h0C);
    check("t4_no_strobe", {mem_read, mem_write}, 2'b00);
    tick(); @(negedge clk);
    check("t4_irq_ack", irq_ack, 1'b1);
    check("t4_wait", cpu_wait, 1'b1);
    drain(50);
    idle(5);

    // PRC write
    push_prc(1, 24'h002000, 8'hA5);
    drain(50);
    @(negedge clk);
    check("t6_mem_write", mem_write, 1'b1);
    check("t6_mem_read", mem_read, 1'b0);
    check("t6_write_data", mem_write_data, 8'hA5);
    idle(5);

    // Reset in the middle of a burst
    for (int i = 0; i < 10; i++) push_prc(0, 24'h005000 + 24'(i), 8'h00);
    prc_issued = 0;
    for (int i = 0; i < 30 && prc_issued < 5; i++) tick();
    check("t5_reached_5", prc_issued, 5);
    tick();
    reset = 1'b1;
    prc_work.delete();
    prc_hold = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_gnt", prc_gnt, 1'b0);
    check("t5_wait", cpu_wait, 1'b0);
    push_cpu(2'd2, 24'h006000, 8'h77);
    tick(); @(negedge clk);
    check("t5_cpu_write", mem_write, 1'b1);
    idle(4);

    // Randomized traffic on both masters
    cpu_rand_en = 1'b1;
    prc_gap_pct = 25;
    for (int c = 0; c < 800; c++) begin
      if (prc_work.size() == 0 && $urandom_range(99) < 10) begin
        int n;
        n = int'($urandom_range(40, 1));
        for (int i = 0; i < n; i++) push_prc(1'($urandom), 24'($urandom), 8'($urandom));
      end
      tick();
    end
    cpu_rand_en = 1'b0;
    prc_gap_pct = 0;
    drain(500);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
